// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: writes a selectable pattern over a word window, reads it back and reports mismatches.
module mem_pattern_tester #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 24,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 1024,
    parameter int ADDR_STEP = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              loop,
    input  logic              stop,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_strb,
    output logic              mem_write_strb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [15:0]       pass_count
);
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0]     LAST = IW'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [DATA_W-1:0] CHK  = DATA_W'({(DATA_W + 1) / 2{2'b01}});

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_GUARD, WR_WAIT, RD_ISSUE, RD_GUARD, RD_WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] cnt, walk, pat, expect_d;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        mode_q;
    logic              loop_q, active, launch, step, last, rd_done, mismatch;

    assign active   = state != IDLE && state != DONE;
    assign launch   = !active && start;
    assign step     = mem_ready && (state == WR_WAIT || state == RD_WAIT);
    assign rd_done  = mem_ready && state == RD_WAIT;
    assign last     = idx == LAST;
    // cnt mirrors i modulo 2^DATA_W and walk holds 1 << (i mod DATA_W), avoiding a divider
    assign pat      = mode_q == 2'd0 ? cnt : mode_q == 2'd1 ? ~cnt : mode_q == 2'd2 ? walk : cnt[0] ? ~CHK : CHK;
    assign expect_d = pat ^ {DATA_W{pass_count[0]}};
    assign mismatch = rd_done && mem_rdata != expect_d;

    assign mem_addr       = active ? addr : '0;
    assign mem_wdata      = active ? expect_d : '0;
    assign mem_write_strb = state == WR_ISSUE && mem_ready;
    assign mem_read_strb  = state == RD_ISSUE && mem_ready;
    assign busy           = active;
    assign done           = state == DONE;
    assign pass           = done && err_count == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? WR_ISSUE : state;
            WR_ISSUE:   state_nxt = mem_ready ? WR_GUARD : state;
            WR_GUARD:   state_nxt = WR_WAIT;
            WR_WAIT:    state_nxt = !mem_ready ? state : last ? RD_ISSUE : WR_ISSUE;
            RD_ISSUE:   state_nxt = mem_ready ? RD_GUARD : state;
            RD_GUARD:   state_nxt = RD_WAIT;
            RD_WAIT:    state_nxt = !mem_ready ? state : !last ? RD_ISSUE : (loop_q && !stop) ? WR_ISSUE : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx            <= '0;
            cnt            <= '0;
            walk           <= '0;
            addr           <= '0;
            mode_q         <= '0;
            loop_q         <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass_count     <= '0;
        end else if (launch) begin
            idx            <= '0;
            cnt            <= '0;
            walk           <= DATA_W'(1);
            addr           <= BASE;
            mode_q         <= mode;
            loop_q         <= loop;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            pass_count     <= '0;
        end else if (step) begin
            idx  <= last ? '0 : idx + 1'b1;
            cnt  <= last ? '0 : cnt + 1'b1;
            walk <= last ? DATA_W'(1) : {walk[DATA_W-2:0], walk[DATA_W-1]};
            addr <= last ? BASE : addr + STEP;
            if (mismatch) begin
                if (err_count == '0) begin
                    first_err_addr <= addr;
                    first_err_data <= mem_rdata;
                end
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
            end
            if (rd_done && last)
                pass_count <= pass_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_pattern_tester.sv
// tb_mem_pattern_tester: random runs of mem_pattern_tester against a latency-randomised memory model
// with read fault injection, checked by a transaction-level reference of the expected access stream.
module tb_mem_pattern_tester;
    localparam int NW = 18;
    localparam logic [23:0] BASE = 24'hFFFFFC;

    logic        clk = 0, reset_n, start, loop, stop, mem_ready;
    logic [1:0]  mode;
    logic [23:0] mem_addr, first_err_addr;
    logic        mem_read_strb, mem_write_strb, busy, done, pass;
    logic [15:0] mem_wdata, mem_rdata, err_count, first_err_data, pass_count;

    mem_pattern_tester #(.DATA_W(16), .ADDR_W(24), .BASE_ADDR(32'hFFFFFC), .NUM_WORDS(NW), .ADDR_STEP(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .loop(loop), .stop(stop),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_read_strb(mem_read_strb),
        .mem_write_strb(mem_write_strb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data), .pass_count(pass_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int m, input int i, input int p);
        logic [15:0] v;
        case (m)
            0:       v = 16'(i);
            1:       v = ~16'(i);
            2:       v = 16'(1) << (i % 16);
            default: v = (i % 2) ? 16'hAAAA : 16'h5555;
        endcase
        return (p % 2) ? ~v : v;
    endfunction

    function automatic logic [23:0] ea(input int i);
        return 24'(32'(BASE) + 32'(i) * 2);
    endfunction

    // memory controller model: busy 1..4 cycles per access, optional single-bit read corruption
    logic [15:0] mem [logic [23:0]];
    int          busy_cnt, fault_pct;
    logic        c_rd;
    logic [23:0] c_addr;
    logic [15:0] c_mask;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready <= 1'b1;
            busy_cnt  <= 0;
            mem_rdata <= 16'h0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                mem_ready <= 1'b1;
                if (c_rd)
                    mem_rdata <= (mem.exists(c_addr) ? mem[c_addr] : 16'h0) ^ c_mask;
            end
        end else if (mem_ready && (mem_write_strb || mem_read_strb)) begin
            mem_ready <= 1'b0;
            busy_cnt  <= int'($urandom_range(1, 4));
            c_rd      <= mem_read_strb;
            c_addr    <= mem_addr;
            c_mask    <= (int'($urandom_range(0, 99)) < fault_pct) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            if (mem_write_strb)
                mem[mem_addr] = mem_wdata;
        end
    end

    // reference: expected access order, addresses, data and the error bookkeeping of the run
    int          run_mode, wi, ri, pi, m_err;
    bit          phase_rd, rd_pend, prev_strb;
    logic [15:0] rd_exp, m_fd;
    logic [23:0] rd_addr, m_fa;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_pend && mem_ready) begin
                rd_pend = 0;
                if (mem_rdata !== rd_exp) begin
                    if (m_err == 0) begin
                        m_fa = rd_addr;
                        m_fd = mem_rdata;
                    end
                    m_err++;
                end
            end
            if (mem_write_strb || mem_read_strb) begin
                check("strb_ready", mem_ready, 1);
                check("strb_both", mem_write_strb && mem_read_strb, 0);
                check("strb_len", prev_strb, 0);
                if (mem_write_strb) begin
                    check("wr_phase", phase_rd, 0);
                    check("wr_addr", mem_addr, ea(wi));
                    check("wr_data", mem_wdata, pat(run_mode, wi, pi));
                    if (++wi == NW) begin
                        wi = 0;
                        phase_rd = 1;
                    end
                end else begin
                    check("rd_phase", phase_rd, 1);
                    check("rd_addr", mem_addr, ea(ri));
                    rd_pend = 1;
                    rd_exp  = pat(run_mode, ri, pi);
                    rd_addr = ea(ri);
                    if (++ri == NW) begin
                        ri = 0;
                        phase_rd = 0;
                        pi++;
                    end
                end
            end
            prev_strb = mem_write_strb || mem_read_strb;
        end
    end

    task automatic arm(input int m, input int fp);
        run_mode = m; fault_pct = fp;
        wi = 0; ri = 0; pi = 0; m_err = 0; m_fa = 0; m_fd = 0;
        phase_rd = 0; rd_pend = 0; prev_strb = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_pc"}, pass_count, 0);
        check({tag, "_fea"}, first_err_addr, 0);
        check({tag, "_fed"}, first_err_data, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_strb"}, {mem_write_strb, mem_read_strb}, 0);
    endtask

    task automatic run(input int m, input bit lp, input int np_in, input int fp);
        int cyc, hold, np;
        np = lp ? np_in : 1;
        hold = int'($urandom_range(1, 20));
        arm(m, fp);
        @(negedge clk);
        mode = 2'(m); loop = lp; stop = 0; start = 1;
        @(negedge clk);
        check("busy_on", busy, 1);
        check("done_clr", done, 0);
        check("pc_clr", pass_count, 0);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == hold) start = 0;
            if (lp) begin
                if (pi == np - 1 && wi > 0) stop = 1;
            end else
                stop = 1'($urandom_range(0, 1));
        end
        check("timeout", cyc < 5000, 1);
        check("done", done, 1);
        check("busy_off", busy, 0);
        check("pass", pass, m_err == 0);
        check("err_count", err_count, m_err);
        check("first_err_addr", first_err_addr, m_fa);
        check("first_err_data", first_err_data, m_fd);
        check("pass_count", pass_count, np);
        check("passes_seen", pi, np);
        start = 0; stop = 0;
        repeat (2) @(negedge clk);
        check("done_hold", done, 1);
    endtask

    task automatic reset_mid_run();
        int cyc;
        arm(0, 0);
        @(negedge clk);
        mode = 0; loop = 1; stop = 0; start = 1;
        @(negedge clk);
        start = 0;
        cyc = 0;
        while ((wi < 5 || mem_ready) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reach", cyc < 500, 1);
        #2 reset_n = 0;
        #1 check_idle_outputs("rst_async");
        @(negedge clk);
        reset_n = 1;
        loop = 0;
    endtask

    initial begin
        reset_n = 0; start = 0; mode = 0; loop = 0; stop = 0;
        arm(0, 0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1;
        run(0, 0, 1, 0);
        run(0, 0, 1, 25);
        run(2, 1, 2, 0);
        run(1, 1, 3, 30);
        run(3, 0, 1, 100);
        reset_mid_run();
        run(2, 1, 2, 10);
        for (int k = 0; k < 6; k++)
            run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                ($urandom_range(0, 2) == 0) ? 20 : 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
